// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Purpose : shared definitions for the two-port SRAM arbiter.
//           - owner_e  : bus ownership state (free, or locked to one port)
//           - PORT0/1  : index of each requester in the grant vector
//           - tie_gnt  : round-robin tie-break, used when SRAM_ARB_RR_EN is set
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_e;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    // Two requesters tie: the port that was not served last wins.
    // Returns a one-hot grant vector {m1, m0}.
    function automatic logic [1:0] tie_gnt(input logic last);
        return last ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Purpose : bundles both requester ports, the shared read-data return and the
//           single-port SRAM pins.
// Modports:
//   slave  - arbiter view: request inputs, gnt/rvalid/rdata outputs, SRAM pins
//   master - requester view (m0 and m1 sides): drives requests, sees grants
// Signals : mN_req/we/lock/addr/wdata, mN_gnt, mN_rvalid, m_rdata,
//           sram_en/we/addr/wdata, sram_rdata
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  sram_en, sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Purpose : shares one single-port synchronous SRAM (1-cycle read latency)
//           between m0 (sector loader, writes) and m1 (scanner, reads).
//           One access per cycle, grant is combinational, read data comes back
//           one cycle later with a per-port rvalid strobe. A grant taken with
//           mN_lock=1 keeps the SRAM reserved for that port (bursts).
// Ports   : clk, reset_n (async, active low), bus (sram_arbiter_if.slave)
// Config  : SRAM_ARB_RR_EN defined   -> round-robin on a tie
//           SRAM_ARB_RR_EN undefined -> m0 always wins a tie
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);

    owner_e     owner_q;
    logic [1:0] rvalid_q;    // per-port read-return pipe, bit = port index
    logic [1:0] gnt;
`ifdef SRAM_ARB_RR_EN
    logic       last_q;      // port served by the most recent grant
`endif

    // Grant selection. While a port owns the bus only it can be granted;
    // the other port simply sees gnt=0 and keeps holding its request.
    always_comb begin
        gnt = 2'b00;
        case (owner_q)
            OWN0:    gnt[PORT0] = bus.m0_req;
            OWN1:    gnt[PORT1] = bus.m1_req;
            default: begin
                if (bus.m0_req && bus.m1_req) begin
`ifdef SRAM_ARB_RR_EN
                    gnt = tie_gnt(last_q);
`else
                    gnt[PORT0] = 1'b1;
`endif
                end else begin
                    gnt[PORT0] = bus.m0_req;
                    gnt[PORT1] = bus.m1_req;
                end
            end
        endcase
    end

    // Ownership is decided purely by the grant just issued: a locked grant
    // reserves the bus, anything else (unlocked grant or dropped req) frees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q  <= OWN_NONE;
            rvalid_q <= 2'b00;
`ifdef SRAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            if (gnt[PORT0] && bus.m0_lock)
                owner_q <= OWN0;
            else if (gnt[PORT1] && bus.m1_lock)
                owner_q <= OWN1;
            else
                owner_q <= OWN_NONE;

            rvalid_q <= {gnt[PORT1] & ~bus.m1_we, gnt[PORT0] & ~bus.m0_we};
`ifdef SRAM_ARB_RR_EN
            if (|gnt)
                last_q <= gnt[PORT1];
`endif
        end
    end

    assign bus.m0_gnt    = gnt[PORT0];
    assign bus.m1_gnt    = gnt[PORT1];
    assign bus.m0_rvalid = rvalid_q[PORT0];
    assign bus.m1_rvalid = rvalid_q[PORT1];
    assign bus.m_rdata   = bus.sram_rdata;

    // SRAM pins are driven to zero whenever nothing is granted.
    assign bus.sram_en    = |gnt;
    assign bus.sram_we    = gnt[PORT0] ? bus.m0_we    : gnt[PORT1] ? bus.m1_we    : 1'b0;
    assign bus.sram_addr  = gnt[PORT0] ? bus.m0_addr  : gnt[PORT1] ? bus.m1_addr  : '0;
    assign bus.sram_wdata = gnt[PORT0] ? bus.m0_wdata : gnt[PORT1] ? bus.m1_wdata : '0;

endmodule
